// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by both the transmit serializer and the receive demultiplexer.
package tdm_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;
endpackage

// File: rtl/demux_dec_4_16.sv
// One-hot slot decoder: turns a slot index plus strobe into a per-bit write enable.
module demux_dec_4_16 #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_OUT-1:0] onehot
);
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == SEL_W'(gi));
  end
endmodule

// File: rtl/tdm_demux_16.sv
// Receive-side 1:16 TDM demultiplexer with frame-lock tracking and a flywheel
// that tolerates up to MISS_MAX-1 missing frame markers.
module tdm_demux_16 #(
  parameter int N_CH     = tdm_pkg::N_CH,
  parameter int SEL_W    = tdm_pkg::SEL_W,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             frame_sync,
  output logic [N_CH-1:0]  dout,
  output logic             valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);
  import tdm_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
  localparam logic [1:0]       MISS_LIM  = 2'(MISS_MAX);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [1:0]       miss_q, miss_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sync_err_q, sync_err_d;

  logic             cap_en;
  logic [SEL_W-1:0] cap_idx;
  logic [1:0]       miss_inc;
  logic [N_CH-1:0]  wr_en;

  demux_dec_4_16 #(
    .N_OUT (N_CH),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (cap_idx),
    .en     (cap_en),
    .onehot (wr_en)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    miss_d     = miss_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    cap_en     = 1'b0;
    cap_idx    = slot_q;
    miss_inc   = (miss_q == MISS_LIM) ? miss_q : miss_q + 2'd1;

    if (en) begin
      if (state_q == UNLOCKED) begin
        if (frame_sync) begin
          state_d = LOCKED;
          cap_en  = 1'b1;
          cap_idx = '0;
          slot_d  = SEL_W'(1);
          miss_d  = 2'd0;
        end
      end else if (frame_sync) begin
        // A marker anywhere restarts the frame; a misplaced one also drops the partial word.
        sync_err_d = (slot_q != '0);
        cap_en     = 1'b1;
        cap_idx    = '0;
        slot_d     = SEL_W'(1);
        miss_d     = 2'd0;
      end else if ((slot_q == '0) && (miss_inc == MISS_LIM)) begin
        state_d = UNLOCKED;
        slot_d  = '0;
        miss_d  = miss_inc;
      end else begin
        cap_en = 1'b1;
        slot_d = slot_q + 1'b1;
        if (slot_q == '0) begin
          miss_d = miss_inc;
        end
        if (slot_q == LAST_SLOT) begin
          dout_d  = {din, shadow_q[N_CH-2:0]};
          valid_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < N_CH; k++) begin
      if (wr_en[k]) begin
        shadow_d[k] = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      slot_q     <= '0;
      miss_q     <= 2'd0;
      shadow_q   <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      miss_q     <= miss_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign dout     = dout_q;
  assign valid    = valid_q;
  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;
endmodule
